uart_reg_master: RTL and testbench

//  UART host-side initiator for the W/R/B/b register-access protocol: turns a parallel request into

---
 rtl/uart_reg_master.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_reg_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_master.sv
// UART host-side initiator for the W/R/B/b register protocol: serialises command/address/length/
// payload bytes on uart_tx and returns read-response bytes collected from uart_rx (8N1, LSB first).
module uart_reg_master #(
    parameter int CLK_FREQ     = 27000000,
    parameter int BAUD_RATE    = 115200,
    parameter int BIT_TIMER    = CLK_FREQ / BAUD_RATE,
    parameter int RESP_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       resetb,
    output logic       uart_tx,
    input  logic       uart_rx,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       timeout_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW        = ($clog2(BIT_TIMER) > 0) ? $clog2(BIT_TIMER) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TIMER - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(BIT_TIMER / 2 - 1);
    localparam logic [15:0]   TO_LAST   = 16'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op);
        case (op)
            2'b00:   cmd_byte = 8'h57;
            2'b01:   cmd_byte = 8'h52;
            2'b10:   cmd_byte = 8'h42;
            default: cmd_byte = 8'h62;
        endcase
    endfunction

    state_t        r_state;
    logic [1:0]    r_op;
    logic [7:0]    r_addr;
    logic [7:0]    r_len;
    logic [7:0]    r_cnt;
    logic [15:0]   r_to;
    logic          r_rdy_en;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_done;
    logic          r_timeout;
    logic          r_ferr;

    logic          r_tx;
    logic          r_tx_active;
    logic [3:0]    r_tx_idx;
    logic [TW-1:0] r_tx_timer;
    logic [7:0]    r_tx_byte;

    rx_state_t     r_rx_st;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic [TW-1:0] r_rx_timer;
    logic [2:0]    r_rx_idx;
    logic [7:0]    r_rx_sr;

    logic          w_accept;
    logic          w_empty_blk;
    logic          w_tx_bit_end;
    logic          w_tx_frame_end;
    logic          w_tx_load;
    logic [7:0]    w_tx_data;
    logic          w_rx;
    logic          w_rx_fall;
    logic          w_rx_stop;
    logic          w_rx_ok;
    logic          w_rx_bad;

    assign req_ready   = r_rdy_en && (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign wr_ready    = (r_state == S_DATA) && !r_tx_active && (r_cnt != 8'd0);
    assign uart_tx     = r_tx;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign done        = r_done;
    assign timeout_err = r_timeout;
    assign frame_err   = r_ferr;

    assign w_accept       = req_valid && req_ready;
    assign w_empty_blk    = req_op[1] && (req_len == 8'd0);
    assign w_tx_bit_end   = r_tx_active && (r_tx_timer == BIT_LAST);
    assign w_tx_frame_end = w_tx_bit_end && (r_tx_idx == 4'd9);
    assign w_rx           = r_rx_s2;
    assign w_rx_fall      = r_rx_s3 && !r_rx_s2;
    assign w_rx_stop      = (r_rx_st == RX_STOP) && (r_rx_timer == BIT_LAST);
    assign w_rx_ok        = w_rx_stop && w_rx;
    assign w_rx_bad       = w_rx_stop && !w_rx;

    // Byte handed to the shifter this cycle; a load on a frame end gives back-to-back frames.
    always_comb begin
        w_tx_load = 1'b0;
        w_tx_data = 8'h00;
        case (r_state)
            S_IDLE: if (w_accept && !w_empty_blk) begin
                w_tx_load = 1'b1;
                w_tx_data = cmd_byte(req_op);
            end
            S_CMD: if (w_tx_frame_end) begin
                w_tx_load = 1'b1;
                w_tx_data = r_addr;
            end
            S_ADDR: if (w_tx_frame_end && r_op[1]) begin
                w_tx_load = 1'b1;
                w_tx_data = r_len;
            end
            S_DATA: if (wr_valid && wr_ready) begin
                w_tx_load = 1'b1;
                w_tx_data = wr_data;
            end
            default: ;
        endcase
    end

    // TX shifter: idx 0 = start bit, 1..8 = data, 9 = stop.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_idx    <= 4'd0;
            r_tx_timer  <= '0;
            r_tx_byte   <= 8'h00;
        end else if (w_tx_load) begin
            r_tx        <= 1'b0;
            r_tx_active <= 1'b1;
            r_tx_idx    <= 4'd0;
            r_tx_timer  <= '0;
            r_tx_byte   <= w_tx_data;
        end else if (w_tx_frame_end) begin
            r_tx_active <= 1'b0;
        end else if (w_tx_bit_end) begin
            r_tx_timer <= '0;
            r_tx_idx   <= r_tx_idx + 4'd1;
            r_tx       <= (r_tx_idx < 4'd8) ? r_tx_byte[r_tx_idx[2:0]] : 1'b1;
        end else if (r_tx_active) begin
            r_tx_timer <= r_tx_timer + 1'b1;
        end
    end

    // RX: sync, falling-edge start detect, mid-bit sampling.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_st    <= RX_IDLE;
            r_rx_timer <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_sr    <= 8'h00;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            case (r_rx_st)
                RX_IDLE: if (w_rx_fall) begin
                    r_rx_st    <= RX_START;
                    r_rx_timer <= '0;
                end
                RX_START: if (r_rx_timer == HALF_LAST) begin
                    r_rx_st    <= w_rx ? RX_IDLE : RX_DATA;
                    r_rx_timer <= '0;
                    r_rx_idx   <= 3'd0;
                end else begin
                    r_rx_timer <= r_rx_timer + 1'b1;
                end
                RX_DATA: if (r_rx_timer == BIT_LAST) begin
                    r_rx_sr    <= {w_rx, r_rx_sr[7:1]};
                    r_rx_timer <= '0;
                    r_rx_idx   <= r_rx_idx + 3'd1;
                    if (r_rx_idx == 3'd7) r_rx_st <= RX_STOP;
                end else begin
                    r_rx_timer <= r_rx_timer + 1'b1;
                end
                default: if (r_rx_timer == BIT_LAST) begin
                    r_rx_st    <= RX_IDLE;
                    r_rx_timer <= '0;
                end else begin
                    r_rx_timer <= r_rx_timer + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_addr     <= 8'h00;
            r_len      <= 8'h00;
            r_cnt      <= 8'h00;
            r_to       <= 16'h0000;
            r_rdy_en   <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ferr     <= w_rx_bad;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op   <= req_op;
                    r_addr <= req_addr;
                    r_len  <= req_len;
                    if (w_empty_blk) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_CMD;
                    end
                end
                S_CMD: if (w_tx_frame_end) r_state <= S_ADDR;
                S_ADDR: if (w_tx_frame_end) begin
                    case (r_op)
                        2'b00: begin
                            r_state <= S_DATA;
                            r_cnt   <= 8'd1;
                        end
                        2'b01: begin
                            r_state <= S_WAIT;
                            r_cnt   <= 8'd1;
                            r_to    <= 16'h0000;
                        end
                        default: r_state <= S_LEN;
                    endcase
                end
                S_LEN: if (w_tx_frame_end) begin
                    r_cnt <= r_len;
                    r_to  <= 16'h0000;
                    r_state <= (r_op == 2'b10) ? S_DATA : S_WAIT;
                end
                S_DATA: begin
                    if (wr_valid && wr_ready) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (w_tx_frame_end && (r_cnt == 8'd0)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                // A byte landing on the timeout cycle wins over the timeout.
                S_WAIT: begin
                    if (w_rx_ok) begin
                        r_rd_data  <= r_rx_sr;
                        r_rd_valid <= 1'b1;
                        r_to       <= 16'h0000;
                        r_cnt      <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_rx_bad) begin
                        r_to <= 16'h0000;
                    end else if (r_to == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to <= r_to + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: serial monitor on uart_tx, scripted slave on uart_rx,
// hand-computed frame contents and cycle timings.
module tb_uart_reg_master;

    localparam int BT = 8;

    logic       clk = 1'b0;
    logic       resetb;
    logic       uart_tx;
    logic       uart_rx;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       timeout_err;
    logic       frame_err;
    logic       busy;

    uart_reg_master #(.BIT_TIMER(BT), .RESP_TIMEOUT(100)) dut (
        .clk(clk), .resetb(resetb), .uart_tx(uart_tx), .uart_rx(uart_rx),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_len(req_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .timeout_err(timeout_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acc_cyc, done_t, rdv_t, fe_t;
    int done_cnt = 0, to_cnt = 0, to_alone = 0, fe_cnt = 0;
    logic [8:0] tx_q[$];
    int         tx_t[$];
    logic [7:0] rd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_t = cyc;
            if (timeout_err === 1'b1) to_cnt++;
        end
        if (timeout_err === 1'b1 && done !== 1'b1) to_alone++;
        if (frame_err === 1'b1) begin
            fe_cnt++;
            fe_t = cyc;
        end
        if (rd_valid === 1'b1) begin
            rd_q.push_back(rd_data);
            rdv_t = cyc;
        end
    end

    // uart_tx monitor: {stop, data} per frame plus the cycle its start bit appeared
    initial begin
        logic [7:0] b;
        logic       st;
        int         t0;
        forever begin
            @(negedge clk);
            if (resetb === 1'b1 && uart_tx === 1'b0) begin
                t0 = cyc;
                repeat (BT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BT) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BT) @(negedge clk);
                st = uart_tx;
                tx_q.push_back({st, b});
                tx_t.push_back(t0);
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        tx_q.delete();
        tx_t.delete();
        rd_q.delete();
    endtask

    task automatic start_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] l);
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_op = op; req_addr = a; req_len = l; req_valid = 1'b1;
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_op    = ~op;
        req_addr  = 8'hFF;
        req_len   = 8'hEE;
    endtask

    task automatic wait_done(input int prev, input int maxc, input string tag);
        int n = 0;
        while (done_cnt == prev && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_cnt, prev + 1);
    endtask

    task automatic wait_tx(input int cnt, input int maxc, input string tag);
        int n = 0;
        while (tx_q.size() < cnt && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, tx_q.size(), cnt);
    endtask

    task automatic wait_wr_ready(input int maxc, input string tag);
        int n = 0;
        while (wr_ready !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, wr_ready, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BT) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        int d0, t0, f0;
        resetb = 1'b0; uart_rx = 1'b1; req_valid = 1'b0; req_op = 2'b00;
        req_addr = 8'h00; req_len = 8'h00; wr_data = 8'h00; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_pulses", {rd_valid, done, timeout_err, frame_err}, 0);
        chk("rst_rd_data", rd_data, 0);
        resetb = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);

        // single write
        wr_data = 8'hA5; wr_valid = 1'b1;
        d0 = done_cnt;
        start_req(2'b00, 8'h10, 8'h00);
        chk("w_busy", busy, 1);
        chk("w_req_ready_low", req_ready, 0);
        wait_done(d0, 2000, "w_done");
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("w_nframes", tx_q.size(), 3);
        chk("w_f0", tx_q[0], 9'h157);
        chk("w_f1", tx_q[1], 9'h110);
        chk("w_f2", tx_q[2], 9'h1A5);
        chk("w_start_lat", tx_t[0], acc_cyc);
        chk("w_b2b", tx_t[1], tx_t[0] + 80);
        chk("w_done_t", done_t, tx_t[2] + 80);
        chk("w_done_once", done_cnt, d0 + 1);
        chk("w_no_rd", rd_q.size(), 0);
        clear_q();

        // single read
        d0 = done_cnt; t0 = to_cnt;
        start_req(2'b01, 8'h22, 8'h00);
        wait_tx(2, 400, "r_cmd_frames");
        repeat (2) @(negedge clk);
        send_rx(8'h3C, 1'b1);
        wait_done(d0, 400, "r_done");
        repeat (3) @(negedge clk);
        chk("r_f0", tx_q[0], 9'h152);
        chk("r_f1", tx_q[1], 9'h122);
        chk("r_nrd", rd_q.size(), 1);
        chk("r_data", rd_q[0], 8'h3C);
        chk("r_done_with_rdv", done_t, rdv_t);
        chk("r_no_timeout", to_cnt, t0);
        clear_q();

        // block read, len 3
        d0 = done_cnt; t0 = to_cnt;
        start_req(2'b11, 8'h40, 8'h03);
        wait_tx(3, 600, "br_cmd_frames");
        repeat (2) @(negedge clk);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        wait_done(d0, 400, "br_done");
        repeat (3) @(negedge clk);
        chk("br_f0", tx_q[0], 9'h162);
        chk("br_f1", tx_q[1], 9'h140);
        chk("br_f2", tx_q[2], 9'h103);
        chk("br_nrd", rd_q.size(), 3);
        chk("br_d0", rd_q[0], 8'h11);
        chk("br_d1", rd_q[1], 8'h22);
        chk("br_d2", rd_q[2], 8'h33);
        chk("br_done_with_rdv", done_t, rdv_t);
        chk("br_no_timeout", to_cnt, t0);
        clear_q();

        // block write, len 2, 50-cycle stall before the second byte
        d0 = done_cnt;
        wr_data = 8'hD0; wr_valid = 1'b1;
        start_req(2'b10, 8'h30, 8'h02);
        wait_wr_ready(1000, "bw_rdy0");
        @(negedge clk);
        wr_valid = 1'b0;
        wait_wr_ready(200, "bw_rdy1");
        repeat (50) @(negedge clk);
        chk("bw_stall_idle", uart_tx, 1);
        chk("bw_stall_rdy", wr_ready, 1);
        wr_data = 8'hD1; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_done(d0, 400, "bw_done");
        repeat (5) @(negedge clk);
        chk("bw_nframes", tx_q.size(), 5);
        chk("bw_f0", tx_q[0], 9'h142);
        chk("bw_f1", tx_q[1], 9'h130);
        chk("bw_f2", tx_q[2], 9'h102);
        chk("bw_f3", tx_q[3], 9'h1D0);
        chk("bw_f4", tx_q[4], 9'h1D1);
        chk("bw_d0_t", tx_t[3], tx_t[2] + 81);
        chk("bw_gap", tx_t[4], tx_t[3] + 131);
        chk("bw_done_t", done_t, tx_t[4] + 80);
        clear_q();

        // read, silent slave -> timeout 100 cycles after WAIT_RESP entry
        d0 = done_cnt; t0 = to_cnt;
        start_req(2'b01, 8'h55, 8'h00);
        wait_done(d0, 600, "to_done");
        chk("to_flag", to_cnt, t0 + 1);
        chk("to_done_t", done_t, tx_t[1] + 180);
        chk("to_f1", tx_q[1], 9'h155);
        chk("to_no_rd", rd_q.size(), 0);
        @(negedge clk);
        chk("to_idle", {busy, req_ready}, 2'b01);
        clear_q();

        // block op with len 0
        d0 = done_cnt; t0 = to_cnt;
        start_req(2'b11, 8'h12, 8'h00);
        chk("z_done_now", done, 1);
        chk("z_req_ready_low", req_ready, 0);
        wait_done(d0, 20, "z_done");
        chk("z_done_t", done_t, acc_cyc);
        repeat (100) @(negedge clk);
        chk("z_no_frames", tx_q.size(), 0);
        chk("z_no_timeout", to_cnt, t0);
        clear_q();

        // framing error on response: dropped, timeout restarts from it
        d0 = done_cnt; t0 = to_cnt; f0 = fe_cnt;
        start_req(2'b01, 8'h66, 8'h00);
        wait_tx(2, 400, "fe_cmd_frames");
        repeat (2) @(negedge clk);
        send_rx(8'hC3, 1'b0);
        wait_done(d0, 600, "fe_done");
        chk("fe_flag", fe_cnt, f0 + 1);
        chk("fe_no_rd", rd_q.size(), 0);
        chk("fe_timeout", to_cnt, t0 + 1);
        chk("fe_to_restart", done_t, fe_t + 100);
        clear_q();

        // reset mid-frame
        d0 = done_cnt;
        wr_data = 8'h99; wr_valid = 1'b1;
        start_req(2'b00, 8'h77, 8'h00);
        repeat (36) @(negedge clk);
        chk("mr_mid_bit3", uart_tx, 0);
        resetb = 1'b0;
        @(negedge clk);
        chk("mr_tx_idle", uart_tx, 1);
        chk("mr_busy", busy, 0);
        chk("mr_req_ready", req_ready, 0);
        resetb = 1'b1; wr_valid = 1'b0;
        @(negedge clk);
        chk("mr_req_ready_back", req_ready, 1);
        repeat (100) @(negedge clk);
        chk("mr_no_done", done_cnt, d0);
        chk("mr_tx_still_idle", uart_tx, 1);
        clear_q();

        // recovery write
        d0 = done_cnt;
        wr_data = 8'h5A; wr_valid = 1'b1;
        start_req(2'b00, 8'h01, 8'h00);
        wait_done(d0, 2000, "rc_done");
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rc_nframes", tx_q.size(), 3);
        chk("rc_f0", tx_q[0], 9'h157);
        chk("rc_f2", tx_q[2], 9'h15A);
        chk("to_only_with_done", to_alone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
